// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the accelerator-backed register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREG_DEF  = 32;
  localparam int unsigned LED_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } acc_state_t;

endpackage

// File: rtl/regfile_acc_if.sv
// Core-side register port plus coprocessor handshake for regfile_acc.
interface regfile_acc_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned LED_W = 8
);
  localparam int unsigned AW = $clog2(NREG);

  logic [AW-1:0]   A1;
  logic [AW-1:0]   A2;
  logic [AW-1:0]   A3;
  logic [XLEN-1:0] WB;
  logic            WE;
  logic [XLEN-1:0] RD1;
  logic [XLEN-1:0] RD2;
  logic            STALL;
  logic [LED_W-1:0] LED;
  logic            ACC_START;
  logic [XLEN-1:0] ACC_OPA;
  logic [XLEN-1:0] ACC_OPB;
  logic            ACC_DONE;
  logic [XLEN-1:0] ACC_RESULT;
  logic            ACC_BUSY;

  modport master (
    output A1, A2, A3, WB, WE, ACC_DONE, ACC_RESULT,
    input  RD1, RD2, STALL, LED, ACC_START, ACC_OPA, ACC_OPB, ACC_BUSY
  );

  modport slave (
    input  A1, A2, A3, WB, WE, ACC_DONE, ACC_RESULT,
    output RD1, RD2, STALL, LED, ACC_START, ACC_OPA, ACC_OPB, ACC_BUSY
  );

endinterface

// File: rtl/regfile_acc_ctl.sv
// Accelerator sequencer: IDLE/BUSY FSM, operand latches and the start pulse.
module regfile_acc_ctl
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_req_i,
  input  logic            done_i,
  input  logic [XLEN-1:0] opa_src_i,
  input  logic [XLEN-1:0] opb_src_i,
  output logic            busy_o,
  output logic            start_o,
  output logic            res_we_c_o,
  output logic [XLEN-1:0] opa_o,
  output logic [XLEN-1:0] opb_o
);

  acc_state_t      state_q, state_d;
  logic            start_q, start_d;
  logic [XLEN-1:0] opa_q, opa_d;
  logic [XLEN-1:0] opb_q, opb_d;

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_req_i) state_d = BUSY;
      BUSY:    if (done_i)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands only latch on an accepted start, so they stay stable while busy.
  always_comb begin
    start_d    = 1'b0;
    opa_d      = opa_q;
    opb_d      = opb_q;
    res_we_c_o = 1'b0;
    if (state_q == IDLE && start_req_i) begin
      start_d = 1'b1;
      opa_d   = opa_src_i;
      opb_d   = opb_src_i;
    end
    if (state_q == BUSY && done_i) begin
      res_we_c_o = 1'b1;
    end
  end

  assign busy_o  = (state_q == BUSY);
  assign start_o = start_q;
  assign opa_o   = opa_q;
  assign opb_o   = opb_q;

endmodule

// File: rtl/regfile_acc.sv
// Integer register file with two registered read ports, write-first bypass and
// an accelerator result slot that stalls reads while the coprocessor is busy.
module regfile_acc
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned NREG    = NREG_DEF,
  parameter int unsigned LED_W   = LED_W_DEF,
  parameter int unsigned LED_REG = 2,
  parameter int unsigned ACC_A   = 1,
  parameter int unsigned ACC_B   = 2,
  parameter int unsigned ACC_RES = NREG - 1
) (
  input  logic          CLK,
  input  logic          RST,
  regfile_acc_if.slave  bus
);

  localparam int unsigned AW = $clog2(NREG);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] rd1_q, rd1_d;
  logic [XLEN-1:0] rd2_q, rd2_d;
  logic            wr_en_c;
  logic            start_req_c;
  logic            stall_c;
  logic            busy;
  logic            res_we_c;

  // Register 0 and the result slot are never targets of a core write.
  assign wr_en_c     = bus.WE && (bus.A3 != '0) && (bus.A3 != AW'(ACC_RES));
  assign start_req_c = wr_en_c && (bus.A3 == AW'(ACC_B));
  assign stall_c     = busy && ((bus.A1 == AW'(ACC_RES)) || (bus.A2 == AW'(ACC_RES)));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else begin
      if (wr_en_c)  regs_q[bus.A3]  <= bus.WB;
      if (res_we_c) regs_q[ACC_RES] <= bus.ACC_RESULT;
    end
  end

  // Read muxes: hold on stall, zero for x0, otherwise write-first bypass.
  always_comb begin
    rd1_d = rd1_q;
    rd2_d = rd2_q;
    if (!stall_c) begin
      if (bus.A1 == '0)                       rd1_d = '0;
      else if (wr_en_c && bus.A3 == bus.A1)   rd1_d = bus.WB;
      else                                    rd1_d = regs_q[bus.A1];
      if (bus.A2 == '0)                       rd2_d = '0;
      else if (wr_en_c && bus.A3 == bus.A2)   rd2_d = bus.WB;
      else                                    rd2_d = regs_q[bus.A2];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
    end
  end

  regfile_acc_ctl #(
    .XLEN (XLEN)
  ) u_ctl (
    .clk_i       (CLK),
    .rst_ni      (RST),
    .start_req_i (start_req_c),
    .done_i      (bus.ACC_DONE),
    .opa_src_i   (regs_q[ACC_A]),
    .opb_src_i   (bus.WB),
    .busy_o      (busy),
    .start_o     (bus.ACC_START),
    .res_we_c_o  (res_we_c),
    .opa_o       (bus.ACC_OPA),
    .opb_o       (bus.ACC_OPB)
  );

  assign bus.RD1      = rd1_q;
  assign bus.RD2      = rd2_q;
  assign bus.STALL    = stall_c;
  assign bus.ACC_BUSY = busy;
  assign bus.LED      = regs_q[LED_REG][LED_W-1:0];

endmodule
